// File: rtl/xor_swap_engine.sv
// ============================================================================
//  Module   : xor_swap_engine
//  Purpose  : Handshaked operand exchange (unconditional or compare-exchange)
//             performed in place with a three-step XOR sequence.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module xor_swap_engine #(
    parameter int WIDTH   = 13,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_a,
    output logic [WIDTH-1:0]   out_b,
    output logic               out_swapped,
    output logic               busy,
    output logic [COUNT_W-1:0] swap_cnt
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CMP  = 3'd1;
    localparam logic [2:0] S_X1   = 3'd2;
    localparam logic [2:0] S_X2   = 3'd3;
    localparam logic [2:0] S_X3   = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic [COUNT_W-1:0] c_cnt_max = {COUNT_W{1'b1}};

    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic [WIDTH-1:0]   r_ra;
    logic [WIDTH-1:0]   r_rb;
    logic               r_mode;
    logic               r_swp;
    logic               w_swp;
    logic               w_accept;
    logic               w_done_hs;

    logic               r_in_ready;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_a;
    logic [WIDTH-1:0]   r_out_b;
    logic               r_out_swapped;
    logic               r_busy;
    logic [COUNT_W-1:0] r_swap_cnt;

    logic               w_in_ready_nxt;
    logic               w_out_valid_nxt;
    logic               w_busy_nxt;
    logic               w_load_out;
    logic [WIDTH-1:0]   w_out_a_nxt;
    logic [WIDTH-1:0]   w_out_b_nxt;
    logic               w_out_swapped_nxt;

    assign w_swp     = !r_mode || (r_ra > r_rb);
    assign w_accept  = (r_state == S_IDLE) && in_valid && r_in_ready;
    assign w_done_hs = (r_state == S_DONE) && r_out_valid && out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_CMP;
            S_CMP:   w_state_next = w_swp ? S_X1 : S_DONE;
            S_X1:    w_state_next = S_X2;
            S_X2:    w_state_next = S_X3;
            S_X3:    w_state_next = S_DONE;
            S_DONE:  if (w_done_hs) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs.
    // The swap path publishes on the X3->DONE edge; the compare-only path
    // publishes its result one cycle after entering DONE.
    always_comb begin
        w_in_ready_nxt    = (w_state_next == S_IDLE);
        w_busy_nxt        = (w_state_next != S_IDLE);
        w_out_valid_nxt   = (w_state_next == S_DONE) &&
                            ((r_state == S_DONE) || (r_state == S_X3));
        w_load_out        = (w_state_next == S_DONE) && (r_state != S_DONE);
        w_out_a_nxt       = (r_state == S_X3) ? (r_ra ^ r_rb) : r_ra;
        w_out_b_nxt       = r_rb;
        w_out_swapped_nxt = (r_state == S_X3);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_in_ready    <= 1'b1;
            r_busy        <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_a       <= '0;
            r_out_b       <= '0;
            r_out_swapped <= 1'b0;
            r_swap_cnt    <= '0;
        end else begin
            r_in_ready  <= w_in_ready_nxt;
            r_busy      <= w_busy_nxt;
            r_out_valid <= w_out_valid_nxt;
            if (w_load_out) begin
                r_out_a       <= w_out_a_nxt;
                r_out_b       <= w_out_b_nxt;
                r_out_swapped <= w_out_swapped_nxt;
            end
            if (w_done_hs && r_swp && (r_swap_cnt != c_cnt_max)) begin
                r_swap_cnt <= r_swap_cnt + 1'b1;
            end
        end
    end

    // Working registers: XOR exchange without a temporary
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ra   <= '0;
            r_rb   <= '0;
            r_mode <= 1'b0;
            r_swp  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_ra   <= in_a;
                    r_rb   <= in_b;
                    r_mode <= in_mode;
                end
                S_CMP:   r_swp <= w_swp;
                S_X1:    r_ra  <= r_ra ^ r_rb;
                S_X2:    r_rb  <= r_ra ^ r_rb;
                S_X3:    r_ra  <= r_ra ^ r_rb;
                default: ;
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_a       = r_out_a;
    assign out_b       = r_out_b;
    assign out_swapped = r_out_swapped;
    assign busy        = r_busy;
    assign swap_cnt    = r_swap_cnt;

endmodule

`default_nettype wire

// File: tb/tb_xor_swap_engine.sv
// ============================================================================
//  Module   : tb_xor_swap_engine
//  Purpose  : Directed self-checking bench for xor_swap_engine.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_xor_swap_engine;

    localparam int WIDTH = 13;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic             out_swapped;
    logic             busy;
    logic [7:0]       swap_cnt;

    logic             in_ready2;
    logic             out_valid2;
    logic [WIDTH-1:0] out_a2;
    logic [WIDTH-1:0] out_b2;
    logic             out_swapped2;
    logic             busy2;
    logic [1:0]       swap_cnt2;

    int n_checks;
    int n_pass;

    xor_swap_engine #(.WIDTH(WIDTH), .COUNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_swapped(out_swapped),
        .busy(busy), .swap_cnt(swap_cnt)
    );

    // Narrow-counter instance shares the stimulus to exercise saturation
    xor_swap_engine #(.WIDTH(WIDTH), .COUNT_W(2)) u_dut_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_a(out_a2), .out_b(out_b2), .out_swapped(out_swapped2),
        .busy(busy2), .swap_cnt(swap_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run_txn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic m, output logic [WIDTH-1:0] oa,
                           output logic [WIDTH-1:0] ob, output logic sw,
                           output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        in_a = a; in_b = b; in_mode = m; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        oa = out_a; ob = out_b; sw = out_swapped;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({in_ready, out_valid, busy, out_swapped} !== 4'b1000)
            $display("FAIL reset_flags: got rdy/vld/busy/sw=%b want 1000",
                     {in_ready, out_valid, busy, out_swapped});
        else n_pass++;
        n_checks++;
        if (out_a !== 13'd0 || out_b !== 13'd0 || swap_cnt !== 8'd0)
            $display("FAIL reset_data: got a=%0d b=%0d cnt=%0d want 0/0/0", out_a, out_b, swap_cnt);
        else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_always_swap();
        logic [WIDTH-1:0] oa, ob;
        logic sw;
        int lat;
        run_txn(13'd12, 13'd14, 1'b0, oa, ob, sw, lat);
        n_checks++;
        if (oa !== 13'd14 || ob !== 13'd12 || sw !== 1'b1 || lat != 4)
            $display("FAIL t1_swap: got %0d/%0d sw=%b lat=%0d want 14/12 sw=1 lat=4", oa, ob, sw, lat);
        else n_pass++;
        run_txn(13'd5, 13'd5, 1'b0, oa, ob, sw, lat);
        n_checks++;
        if (oa !== 13'd5 || ob !== 13'd5 || sw !== 1'b1 || lat != 4)
            $display("FAIL eq_mode0: got %0d/%0d sw=%b lat=%0d want 5/5 sw=1 lat=4", oa, ob, sw, lat);
        else n_pass++;
    endtask

    task automatic test_compare_exchange();
        logic [WIDTH-1:0] oa, ob;
        logic sw;
        int lat;
        run_txn(13'd14, 13'd12, 1'b1, oa, ob, sw, lat);
        n_checks++;
        if (oa !== 13'd12 || ob !== 13'd14 || sw !== 1'b1 || lat != 4)
            $display("FAIL t2_cx_swap: got %0d/%0d sw=%b lat=%0d want 12/14 sw=1 lat=4", oa, ob, sw, lat);
        else n_pass++;
        run_txn(13'd12, 13'd14, 1'b1, oa, ob, sw, lat);
        n_checks++;
        if (oa !== 13'd12 || ob !== 13'd14 || sw !== 1'b0 || lat != 2)
            $display("FAIL t2_cx_keep: got %0d/%0d sw=%b lat=%0d want 12/14 sw=0 lat=2", oa, ob, sw, lat);
        else n_pass++;
        n_checks++;
        if (swap_cnt !== 8'd3)
            $display("FAIL cnt_after_t2: got %0d want 3", swap_cnt);
        else n_pass++;
    endtask

    task automatic test_boundary();
        logic [WIDTH-1:0] oa, ob;
        logic sw;
        int lat;
        run_txn(13'd8191, 13'd0, 1'b1, oa, ob, sw, lat);
        n_checks++;
        if (oa !== 13'd0 || ob !== 13'd8191 || sw !== 1'b1)
            $display("FAIL t3_extremes: got %0d/%0d sw=%b want 0/8191 sw=1", oa, ob, sw);
        else n_pass++;
        run_txn(13'd5, 13'd5, 1'b1, oa, ob, sw, lat);
        n_checks++;
        if (oa !== 13'd5 || ob !== 13'd5 || sw !== 1'b0 || lat != 2)
            $display("FAIL t3_eq_mode1: got %0d/%0d sw=%b lat=%0d want 5/5 sw=0 lat=2", oa, ob, sw, lat);
        else n_pass++;
        run_txn(13'd0, 13'd8191, 1'b0, oa, ob, sw, lat);
        n_checks++;
        if (oa !== 13'd8191 || ob !== 13'd0 || sw !== 1'b1)
            $display("FAIL zero_ones_mode0: got %0d/%0d sw=%b want 8191/0 sw=1", oa, ob, sw);
        else n_pass++;
        n_checks++;
        if (swap_cnt !== 8'd5)
            $display("FAIL cnt_after_t3: got %0d want 5", swap_cnt);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int lat;
        in_a = 13'd3; in_b = 13'd9; in_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        // Garbage offered while busy must be ignored
        in_a = 13'd100; in_b = 13'd200; in_mode = 1'b1;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_a !== 13'd9 || out_b !== 13'd3 ||
                out_swapped !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1)
                $display("FAIL t4_hold[%0d]: got vld=%b %0d/%0d sw=%b rdy=%b busy=%b want 1 9/3 1 0 1",
                         i, out_valid, out_a, out_b, out_swapped, in_ready, busy);
            else n_pass++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || swap_cnt !== 8'd6)
            $display("FAIL t4_release: got rdy=%b busy=%b vld=%b cnt=%0d want 1 0 0 6",
                     in_ready, busy, out_valid, swap_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_midflight();
        bit seen;
        in_a = 13'd7; in_b = 13'd1; in_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || swap_cnt !== 8'd0)
            $display("FAIL t5_reset: got rdy=%b busy=%b vld=%b cnt=%0d want 1 0 0 0",
                     in_ready, busy, out_valid, swap_cnt);
        else n_pass++;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0)
            $display("FAIL t5_no_emit: got out_valid seen=%b want 0", seen);
        else n_pass++;
        // Reset coinciding with an offered handshake
        in_a = 13'd2; in_b = 13'd1; in_valid = 1'b1; rst_n = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; rst_n = 1'b1;
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL reset_vs_hs: got rdy=%b busy=%b want 1 0", in_ready, busy);
        else n_pass++;
    endtask

    task automatic test_saturation();
        logic [WIDTH-1:0] oa, ob;
        logic sw;
        int lat;
        for (int i = 0; i < 5; i++) run_txn(13'(i + 1), 13'(20 + i), 1'b0, oa, ob, sw, lat);
        n_checks++;
        if (swap_cnt2 !== 2'd3 || swap_cnt !== 8'd5)
            $display("FAIL t6_sat: got narrow=%0d wide=%0d want 3 5", swap_cnt2, swap_cnt);
        else n_pass++;
        run_txn(13'd1, 13'd2, 1'b1, oa, ob, sw, lat);
        n_checks++;
        if (swap_cnt2 !== 2'd3 || swap_cnt !== 8'd5 || sw !== 1'b0)
            $display("FAIL t6_nonswap: got narrow=%0d wide=%0d sw=%b want 3 5 0", swap_cnt2, swap_cnt, sw);
        else n_pass++;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_mode   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_always_swap();
        test_compare_exchange();
        test_boundary();
        test_backpressure();
        test_reset_midflight();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
